// File: rtl/isqrt_arb_pkg.sv
// rtl/isqrt_arb_pkg.sv - shared widths, defaults and round-robin pick for the isqrt arbiter
package isqrt_arb_pkg;

  localparam int DATA_W           = 32;
  localparam int RES_W            = 16;
  localparam int N_REQ_DEF        = 4;
  localparam int MAX_INFLIGHT_DEF = 16;
  localparam int RR_MAX           = 8;

  // One-hot grant: first asserted req at or after ptr, wrapping modulo n.
  function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req,
                                                input logic [2:0]        ptr,
                                                input int                n);
    logic [RR_MAX-1:0] grant;
    logic              found;
    logic [2:0]        idx;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < RR_MAX; k++) begin
      idx = 3'((int'(ptr) + k) % n);
      if (k < n && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/isqrt_tag_fifo.sv
// rtl/isqrt_tag_fifo.sv - in-order owner-tag FIFO for outstanding isqrt operations
module isqrt_tag_fifo #(
  parameter  int W     = 2,
  parameter  int DEPTH = 16,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Explicit wrap so non-power-of-two depths still work.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/isqrt_pipe_arbiter.sv
// rtl/isqrt_pipe_arbiter.sv - round-robin sharing of one pipelined isqrt among N_REQ requesters
module isqrt_pipe_arbiter
  import isqrt_arb_pkg::*;
#(
  parameter  int N_REQ        = N_REQ_DEF,
  parameter  int MAX_INFLIGHT = MAX_INFLIGHT_DEF,
  localparam int TAG_W        = $clog2(N_REQ),
  localparam int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_vld,
  output logic [N_REQ-1:0]      req_rdy,
  input  logic [N_REQ*32-1:0]   req_x,
  output logic [N_REQ-1:0]      resp_vld,
  output logic [RES_W-1:0]      resp_y,
  output logic                  isqrt_x_vld,
  output logic [DATA_W-1:0]     isqrt_x,
  input  logic                  isqrt_y_vld,
  input  logic [RES_W-1:0]      isqrt_y,
  output logic [CNT_W-1:0]      inflight,
  output logic                  err_underflow
);

  logic [TAG_W-1:0]  ptr;
  logic [TAG_W-1:0]  acc_idx;
  logic [TAG_W-1:0]  fifo_dout;
  logic [RR_MAX-1:0] req_pad;
  logic [RR_MAX-1:0] grant;
  logic              accept;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;

  always_comb begin
    req_pad             = '0;
    req_pad[N_REQ-1:0]  = req_vld;
    grant               = rr_pick(req_pad, 3'(ptr), N_REQ);
  end

  // No pop bypass: a full FIFO blocks grants even if a result leaves this cycle.
  assign req_rdy = (rst || fifo_full) ? '0 : grant[N_REQ-1:0];

  always_comb begin
    accept  = 1'b0;
    acc_idx = '0;
    isqrt_x = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_vld[i] && req_rdy[i]) begin
        accept  = 1'b1;
        acc_idx = TAG_W'(i);
        isqrt_x = req_x[DATA_W*i +: DATA_W];
      end
    end
  end

  assign isqrt_x_vld = accept;
  assign pop         = isqrt_y_vld && !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (acc_idx == TAG_W'(N_REQ - 1)) ? '0 : acc_idx + 1'b1;
    end
  end

  isqrt_tag_fifo #(
    .W     (TAG_W),
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .din   (acc_idx),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (inflight)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_vld      <= '0;
      resp_y        <= '0;
      err_underflow <= 1'b0;
    end else begin
      resp_vld <= '0;
      if (pop) begin
        resp_vld[fifo_dout] <= 1'b1;
        resp_y              <= isqrt_y;
      end
      if (isqrt_y_vld && fifo_empty) err_underflow <= 1'b1;
    end
  end

endmodule
